cfg_boot_sequencer: RTL

Sequences the dock's shared 8-bit configuration bus (cfg_we / cfg_addr / cfg_wdata) that programs the address-decoder windows (addresses below 0xC0) and the interrupt router (0xC0 and above). After reset it replays a boot table of {addr, data} pairs from a synchronous ROM. Once the table is done it grants the bus to a host write port, which is buffered by a small FIFO. The block is the single master of the config bus; the top level drives cfg_clk from the same clk.

---
 rtl/cfg_boot_sequencer_if.sv | 31 +++
 rtl/cfg_boot_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/cfg_boot_sequencer_if.sv
// Host write port and shared configuration bus of the boot sequencer.
// The sequencer takes the master side, the host/bus environment the slave side.
interface cfg_boot_sequencer_if;
    logic       host_valid;
    logic       host_ready;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       cfg_we;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_wdata;

    modport master (
        input  host_valid,
        input  host_addr,
        input  host_wdata,
        output host_ready,
        output cfg_we,
        output cfg_addr,
        output cfg_wdata
    );

    modport slave (
        output host_valid,
        output host_addr,
        output host_wdata,
        input  host_ready,
        input  cfg_we,
        input  cfg_addr,
        input  cfg_wdata
    );
endinterface

// File: rtl/cfg_boot_sequencer.sv
// Replays a ROM boot table onto the config bus, then drains a host write FIFO.
// Sole master of the config bus; addresses are passed through unfiltered.
module cfg_boot_sequencer #(
    parameter int ROM_AW     = 6,
    parameter int BOOT_LEN   = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reboot,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              boot_done,
    cfg_boot_sequencer_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(BOOT_LEN - 1);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        RST,
        FETCH,
        WRITE,
        DONE
    } state_t;

    state_t state, state_n;

    logic [ROM_AW-1:0] idx, idx_n;
    logic [15:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [PW:0]       count;
    logic              push, pop, full, empty;
    logic              we_n;
    logic [7:0]        addr_n, wdata_n;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Ready stays low for the whole cycle after a reset edge.
    assign bus.host_ready = (state != RST) && !full;
    assign push           = bus.host_valid && bus.host_ready;

    assign rom_addr  = idx;
    assign boot_done = (state == DONE);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        pop     = 1'b0;
        we_n    = 1'b0;
        addr_n  = bus.cfg_addr;
        wdata_n = bus.cfg_wdata;
        unique case (state)
            RST: begin
                state_n = FETCH;
                idx_n   = '0;
            end
            FETCH: state_n = WRITE;
            WRITE: begin
                if (rom_data == 16'hFFFF) begin
                    state_n = DONE;
                end else begin
                    we_n    = 1'b1;
                    addr_n  = rom_data[15:8];
                    wdata_n = rom_data[7:0];
                    if (idx == LAST_IDX) begin
                        state_n = DONE;
                    end else begin
                        idx_n   = idx + ROM_AW'(1);
                        state_n = FETCH;
                    end
                end
            end
            DONE: begin
                // Reboot wins over a pending pop; the FIFO keeps its entry.
                if (reboot) begin
                    idx_n   = '0;
                    state_n = FETCH;
                end else if (!empty) begin
                    pop     = 1'b1;
                    we_n    = 1'b1;
                    addr_n  = mem[rptr][15:8];
                    wdata_n = mem[rptr][7:0];
                end
            end
            default: state_n = RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= RST;
            idx           <= '0;
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            bus.cfg_we    <= 1'b0;
            bus.cfg_addr  <= 8'h00;
            bus.cfg_wdata <= 8'h00;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            bus.cfg_we    <= we_n;
            bus.cfg_addr  <= addr_n;
            bus.cfg_wdata <= wdata_n;
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only slots covered by count are ever read.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {bus.host_addr, bus.host_wdata};
    end
endmodule
